// File: rtl/alu_pkg.sv
// Shared opcode map, compare codes and FSM state for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_MOD  = 4'b1111;

    localparam int CMP_EQ = 1;
    localparam int CMP_GT = 2;
    localparam int CMP_LT = 3;

    typedef enum logic {
        IDLE,
        DIV
    } state_t;

    typedef struct packed {
        logic arith;
        logic lgc;
        logic cmp;
        logic shift;
    } flags_t;

endpackage

// File: rtl/alu_div_seq.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
module alu_div_seq #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    always_comb begin
        shifted = {r, q[WIDTH-1]};
        diff    = shifted - {1'b0, d};
        fits    = ~diff[WIDTH];
        q_next  = {q[WIDTH-2:0], fits};
        r_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= '0;
            r   <= '0;
            d   <= '0;
        end else if (start && !busy) begin
            cnt <= CNT_W'(WIDTH);
            q   <= dividend;
            r   <= '0;
            d   <= divisor;
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            q   <= q_next;
            r   <= r_next;
        end
    end

    // done flags the final step; results are the values that step produces
    assign busy      = (cnt != '0);
    assign done      = (cnt == CNT_W'(1));
    assign quotient  = q_next;
    assign remainder = r_next;

endmodule

// File: rtl/alu_seq.sv
// Registered 16-opcode ALU with valid/ready input and multi-cycle divide/modulo.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             Shift_Flag,
    output logic             Div_By_Zero
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             start;
    logic             is_div;
    logic             op_mod;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] sc_res;
    flags_t           sc_flags;
    logic             sc_dbz;
    flags_t           flags_q;

    alu_div_seq #(.WIDTH(WIDTH)) u_div (
        .clk       (CLK),
        .rst_n     (RST),
        .start     (start),
        .dividend  (A),
        .divisor   (B),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = DIV;
            DIV:  if (div_done || !div_busy) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        In_Ready = (state == IDLE);
        start    = In_Valid && (state == IDLE) && is_div;
    end

    assign accept = In_Valid && In_Ready;

    always_comb begin
        sc_res   = '0;
        sc_flags = '0;
        sc_dbz   = 1'b0;
        is_div   = 1'b0;
        unique case (ALU_FUN)
            OP_ADD:  begin sc_res = A + B;     sc_flags.arith = 1'b1; end
            OP_SUB:  begin sc_res = A - B;     sc_flags.arith = 1'b1; end
            OP_MUL:  begin sc_res = A * B;     sc_flags.arith = 1'b1; end
            OP_AND:  begin sc_res = A & B;     sc_flags.lgc = 1'b1; end
            OP_OR:   begin sc_res = A | B;     sc_flags.lgc = 1'b1; end
            OP_NAND: begin sc_res = ~(A & B);  sc_flags.lgc = 1'b1; end
            OP_NOR:  begin sc_res = ~(A | B);  sc_flags.lgc = 1'b1; end
            OP_XOR:  begin sc_res = A ^ B;     sc_flags.lgc = 1'b1; end
            OP_XNOR: begin sc_res = ~(A ^ B);  sc_flags.lgc = 1'b1; end
            OP_EQ: begin
                sc_res = (A == B) ? WIDTH'(CMP_EQ) : '0;
                sc_flags.cmp = 1'b1;
            end
            OP_GT: begin
                sc_res = (A > B) ? WIDTH'(CMP_GT) : '0;
                sc_flags.cmp = 1'b1;
            end
            OP_LT: begin
                sc_res = (A < B) ? WIDTH'(CMP_LT) : '0;
                sc_flags.cmp = 1'b1;
            end
            OP_SHR:  begin sc_res = A >> 1;    sc_flags.shift = 1'b1; end
            OP_SHL:  begin sc_res = A << 1;    sc_flags.shift = 1'b1; end
            // B==0 resolves in one cycle; otherwise hand off to the divider
            OP_DIV, OP_MOD: begin
                sc_flags.arith = 1'b1;
                if (B == '0) begin
                    sc_res = (ALU_FUN == OP_DIV) ? '1 : A;
                    sc_dbz = 1'b1;
                end else begin
                    is_div = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Out_Valid   <= 1'b0;
            ALU_OUT     <= '0;
            flags_q     <= '0;
            Div_By_Zero <= 1'b0;
            op_mod      <= 1'b0;
        end else begin
            Out_Valid <= 1'b0;
            if (accept) begin
                if (is_div) begin
                    op_mod <= (ALU_FUN == OP_MOD);
                end else begin
                    Out_Valid   <= 1'b1;
                    ALU_OUT     <= sc_res;
                    flags_q     <= sc_flags;
                    Div_By_Zero <= sc_dbz;
                end
            end else if (state == DIV && div_done) begin
                Out_Valid   <= 1'b1;
                ALU_OUT     <= op_mod ? rem : quo;
                flags_q     <= '{arith: 1'b1, default: 1'b0};
                Div_By_Zero <= 1'b0;
            end
        end
    end

    assign Arith_Flag = flags_q.arith;
    assign Logic_Flag = flags_q.lgc;
    assign CMP_Flag   = flags_q.cmp;
    assign Shift_Flag = flags_q.shift;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16.
module tb_alu_seq;

    localparam int W = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         In_Valid;
    logic         In_Ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   ALU_FUN;
    logic         Out_Valid;
    logic [W-1:0] ALU_OUT;
    logic         Arith_Flag;
    logic         Logic_Flag;
    logic         CMP_Flag;
    logic         Shift_Flag;
    logic         Div_By_Zero;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .In_Valid    (In_Valid),
        .In_Ready    (In_Ready),
        .A           (A),
        .B           (B),
        .ALU_FUN     (ALU_FUN),
        .Out_Valid   (Out_Valid),
        .ALU_OUT     (ALU_OUT),
        .Arith_Flag  (Arith_Flag),
        .Logic_Flag  (Logic_Flag),
        .CMP_Flag    (CMP_Flag),
        .Shift_Flag  (Shift_Flag),
        .Div_By_Zero (Div_By_Zero)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
    endfunction

    // single-cycle op: In_Valid stays high so calls chain back-to-back
    task automatic op1(input string tag, input logic [3:0] fun,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic [3:0] fl,
                       input logic dbz);
        In_Valid = 1'b1;
        A = a;
        B = b;
        ALU_FUN = fun;
        tick();
        chk({tag, "_ov"}, 32'(Out_Valid), 32'd1);
        chk({tag, "_out"}, 32'(ALU_OUT), 32'(res));
        chk({tag, "_flags"}, 32'(flags()), 32'(fl));
        chk({tag, "_dbz"}, 32'(Div_By_Zero), 32'(dbz));
        chk({tag, "_rdy"}, 32'(In_Ready), 32'd1);
    endtask

    // multi-cycle op with a decoy ADD held on the inputs while busy
    task automatic run_div(input string tag, input logic [3:0] fun,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res);
        int lat;
        int low;
        In_Valid = 1'b1;
        A = a;
        B = b;
        ALU_FUN = fun;
        tick();
        A = 16'd5;
        B = 16'd5;
        ALU_FUN = 4'b0000;
        lat = 0;
        low = 0;
        while (Out_Valid !== 1'b1 && lat < 40) begin
            if (In_Ready === 1'b0) low++;
            tick();
            lat++;
        end
        In_Valid = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd16);
        chk({tag, "_rdylow"}, 32'(low), 32'd16);
        chk({tag, "_out"}, 32'(ALU_OUT), 32'(res));
        chk({tag, "_flags"}, 32'(flags()), 32'b1000);
        chk({tag, "_dbz"}, 32'(Div_By_Zero), 32'd0);
        tick();
        chk({tag, "_pulse"}, 32'(Out_Valid), 32'd0);
        chk({tag, "_hold"}, 32'(ALU_OUT), 32'(res));
    endtask

    initial begin
        int cnt;
        RST = 1'b0;
        In_Valid = 1'b0;
        A = '0;
        B = '0;
        ALU_FUN = 4'b0000;
        tick();
        tick();
        chk("rst_out", 32'(ALU_OUT), 32'd0);
        chk("rst_flags", 32'(flags()), 32'd0);
        chk("rst_ov", 32'(Out_Valid), 32'd0);
        chk("rst_dbz", 32'(Div_By_Zero), 32'd0);
        RST = 1'b1;
        tick();
        chk("rst_rdy", 32'(In_Ready), 32'd1);

        op1("add", 4'b0000, 16'hFFFF, 16'h0002, 16'h0001, 4'b1000, 1'b0);
        op1("nand", 4'b0110, 16'h00F0, 16'h0FF0, 16'hFF0F, 4'b0100, 1'b0);
        op1("gt", 4'b1011, 16'd5, 16'd3, 16'h0002, 4'b0010, 1'b0);
        In_Valid = 1'b0;
        tick();
        chk("idle_ov", 32'(Out_Valid), 32'd0);
        chk("idle_hold", 32'(ALU_OUT), 32'h0002);
        chk("idle_flags", 32'(flags()), 32'b0010);

        RST = 1'b0;
        #1;
        chk("arst_out", 32'(ALU_OUT), 32'd0);
        chk("arst_flags", 32'(flags()), 32'd0);
        chk("arst_ov", 32'(Out_Valid), 32'd0);
        tick();
        RST = 1'b1;
        tick();
        chk("arst_rdy", 32'(In_Ready), 32'd1);

        op1("sub", 4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000, 1'b0);
        op1("mul", 4'b0010, 16'h0100, 16'h0101, 16'h0100, 4'b1000, 1'b0);
        op1("xnor", 4'b1001, 16'hF0F0, 16'hFF00, 16'hF00F, 4'b0100, 1'b0);
        op1("eq", 4'b1010, 16'h1234, 16'h1234, 16'h0001, 4'b0010, 1'b0);
        op1("lt", 4'b1100, 16'd3, 16'd5, 16'h0003, 4'b0010, 1'b0);
        op1("ltno", 4'b1100, 16'd5, 16'd3, 16'h0000, 4'b0010, 1'b0);
        op1("shr", 4'b1101, 16'h8001, 16'h0000, 16'h4000, 4'b0001, 1'b0);
        op1("shl", 4'b1110, 16'h8001, 16'h0000, 16'h0002, 4'b0001, 1'b0);
        In_Valid = 1'b0;
        tick();

        run_div("div1000_7", 4'b0011, 16'd1000, 16'd7, 16'd142);
        run_div("mod1000_7", 4'b1111, 16'd1000, 16'd7, 16'd6);
        run_div("modffff_1", 4'b1111, 16'hFFFF, 16'd1, 16'd0);
        run_div("div3_9", 4'b0011, 16'd3, 16'd9, 16'd0);
        run_div("mod3_9", 4'b1111, 16'd3, 16'd9, 16'd3);
        run_div("divffff_1", 4'b0011, 16'hFFFF, 16'd1, 16'hFFFF);
        run_div("divffff_3", 4'b0011, 16'hFFFF, 16'd3, 16'h5555);

        op1("div0", 4'b0011, 16'h1234, 16'h0000, 16'hFFFF, 4'b1000, 1'b1);
        op1("mod0", 4'b1111, 16'h1234, 16'h0000, 16'h1234, 4'b1000, 1'b1);
        op1("and", 4'b0100, 16'h1234, 16'h00FF, 16'h0034, 4'b0100, 1'b0);
        In_Valid = 1'b0;
        tick();

        In_Valid = 1'b1;
        A = 16'hFFFF;
        B = 16'd3;
        ALU_FUN = 4'b0011;
        tick();
        In_Valid = 1'b0;
        repeat (7) tick();
        chk("mid_busy", 32'(In_Ready), 32'd0);
        RST = 1'b0;
        #1;
        chk("mid_out", 32'(ALU_OUT), 32'd0);
        chk("mid_flags", 32'(flags()), 32'd0);
        chk("mid_ov", 32'(Out_Valid), 32'd0);
        chk("mid_dbz", 32'(Div_By_Zero), 32'd0);
        tick();
        tick();
        RST = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            if (Out_Valid === 1'b1) cnt++;
        end
        chk("mid_noov", 32'(cnt), 32'd0);
        chk("mid_rdy", 32'(In_Ready), 32'd1);
        op1("add11", 4'b0000, 16'd1, 16'd1, 16'd2, 4'b1000, 1'b0);
        In_Valid = 1'b0;
        tick();
        chk("end_ov", 32'(Out_Valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor of the 16-bit combinational ALU.
- Same opcode map and flag outputs, plus a valid/ready input handshake and registered outputs.
- Divide is an iterative multi-cycle divider; adds modulo (opcode 4'b1111) and divide-by-zero detection.
- Sits between the operand/decode stage and result writeback.

Parameters:
- WIDTH, 16: operand and result width in bits; legal values 4 to 32.
- CNT_W, $clog2(WIDTH+1): divider iteration counter width. Derived; do not override.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- In_Valid  in  1  operands and opcode are presented this cycle.
- In_Ready  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- ALU_FUN  in  4  opcode.
- Out_Valid  out  1  one-cycle pulse: ALU_OUT and the flags carry a new result.
- ALU_OUT  out  WIDTH  registered result; holds its value between results.
- Arith_Flag  out  1  result came from an arithmetic op; registered and held.
- Logic_Flag  out  1  result came from a logic op; registered and held.
- CMP_Flag  out  1  result came from a compare op; registered and held.
- Shift_Flag  out  1  result came from a shift op; registered and held.
- Div_By_Zero  out  1  last divide or modulo had B==0; registered and held.

Behaviour:
- Reset (RST low, asynchronous): state IDLE. Out_Valid, ALU_OUT, all four flags and Div_By_Zero = 0. In_Ready = 1 once RST is released.
- Accept: an operation is accepted on a rising edge where In_Valid=1 and In_Ready=1. A, B and ALU_FUN are sampled only at that edge.
- Opcodes. All arithmetic is modulo 2^WIDTH.
  - 0000 A+B
  - 0001 A-B
  - 0010 A*B, low WIDTH bits
  - 0011 A/B
  - 0100 AND
  - 0101 OR
  - 0110 NAND
  - 0111 NOR
  - 1000 XOR
  - 1001 XNOR
  - 1010 A==B gives 1, else 0
  - 1011 A>B gives 2, else 0
  - 1100 A<B gives 3, else 0
  - 1101 A>>1, logical
  - 1110 A<<1
  - 1111 A%B
- Flags:
  - Arith_Flag for 0000-0011 and 1111.
  - Logic_Flag for 0100-1001.
  - CMP_Flag for 1010-1100.
  - Shift_Flag for 1101-1110.
  - Exactly one flag is set per result. There is no default case: all 16 codes are defined.
- Single-cycle ops (every opcode except 0011 and 1111, plus divide/modulo with B==0):
  - Result and flags are registered at the accept edge; Out_Valid=1 for the following cycle.
  - Latency 1; state stays IDLE; In_Ready stays 1, so back-to-back ops give Out_Valid every cycle.
- Divide by zero (0011 or 1111 with B==0):
  - Single-cycle.
  - ALU_OUT = all ones for 0011, ALU_OUT = A for 1111.
  - Div_By_Zero=1, Arith_Flag=1.
  - Any other result clears Div_By_Zero.
- State machine, IDLE and DIV:
  - IDLE: In_Ready=1. Accepting 0011 or 1111 with B!=0 moves to DIV and loads the divider with counter = WIDTH.
  - DIV: In_Ready=0 and In_Valid is ignored. Each edge performs one restoring-division step, MSB first, and decrements the counter.
  - On the edge where the counter goes 1 to 0: load ALU_OUT with the quotient (0011) or remainder (1111), set Arith_Flag, set Out_Valid for the next cycle, return to IDLE.
  - Divide latency is WIDTH cycles from the accept edge to the Out_Valid cycle. In_Ready is low for exactly WIDTH cycles.
- Between results: ALU_OUT, the flags and Div_By_Zero hold. Out_Valid=0 whenever no new result was produced.
- Reset mid-divide: the operation is aborted, no Out_Valid is produced, and all outputs take their reset values.
- Boundary cases:
  - A<B divide: quotient 0, remainder A.
  - B==1: quotient A, remainder 0.
  - Full-scale A=2^WIDTH-1 must divide exactly.

Decomposition:
- Package alu_pkg holds:
  - the opcode localparams (OP_ADD through OP_MOD);
  - the compare result codes (CMP_EQ=1, CMP_GT=2, CMP_LT=3);
  - the state enum {IDLE, DIV}.
- Sub-module alu_div_seq: the iterative restoring divider.
  - Inputs: start, dividend, divisor.
  - Outputs: busy, done (1-cycle pulse), quotient, remainder.
  - Parametrised by WIDTH, with the same clock and reset.
- alu_seq owns the handshake, the single-cycle datapath and the output registers.

Test Plan (WIDTH=16):
1. Reset: RST low mid-run → ALU_OUT=0, all flags 0, Out_Valid=0; RST released → In_Ready=1.
2. Back-to-back ADD 0xFFFF+0x0002, then NAND 0x00F0,0x0FF0, then GT 5,3 over three consecutive cycles:
   - Out_Valid high three cycles running.
   - Results in order: ALU_OUT=0x0001 with Arith=1; 0xFF0F with Logic=1; 0x0002 with CMP=1.
3. Divide 1000/7 accepted:
   - In_Ready low for 16 cycles and In_Valid ignored meanwhile.
   - Out_Valid exactly 16 cycles after accept with ALU_OUT=142 (0x008E), Arith=1, Div_By_Zero=0.
4. Modulo 1000%7 → 6 after 16 cycles. Modulo 0xFFFF%1 → 0. Divide 3/9 → 0.
5. Divide 0x1234/0 → ALU_OUT=0xFFFF, Div_By_Zero=1, latency 1. A following AND clears Div_By_Zero.
6. Divide 0xFFFF/3 started, RST pulsed low at cycle 8 → no Out_Valid, outputs 0. After release, ADD 1+1 → ALU_OUT=2 with latency 1.
